// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// The fetch FSM encoding and the reset value of instruction queue entries live here.
package if_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} pairs between memory return and decode.
// A synchronous clear beats both push and pop in the same cycle.
module fetch_queue
   import if_pkg::*;
#(
   parameter  int DEPTH  = 2,
   parameter  int ADDR_W = DEF_ADDR_W,
   parameter  int DATA_W = DEF_DATA_W,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              clear,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic [DATA_W-1:0] push_instr,
   output logic [ADDR_W-1:0] head_pc,
   output logic [DATA_W-1:0] head_instr,
   output logic              empty,
   output logic              full,
   output logic [CNT_W-1:0]  count
);

   logic [ADDR_W-1:0] pc_q    [DEPTH];
   logic [ADDR_W-1:0] pc_d    [DEPTH];
   logic [DATA_W-1:0] instr_q [DEPTH];
   logic [DATA_W-1:0] instr_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push;
   logic              do_pop;

   assign empty      = (count_q == '0);
   assign full       = (count_q == CNT_W'(DEPTH));
   assign count      = count_q;
   assign head_pc    = pc_q[rd_ptr_q];
   assign head_instr = instr_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop && !empty && !clear;
      // A full queue can still take a push when the head leaves in the same cycle.
      do_push  = push && !clear && (!full || do_pop);
      pc_d     = pc_q;
      instr_d  = instr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            pc_d[wr_ptr_q]    = push_pc;
            instr_d[wr_ptr_q] = push_instr;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= DATA_W'(NOP_INSTR);
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding memory read at a time, results queued for decode.
// A flushed read that memory has already accepted is drained in DROP and its data thrown away.
module fetch_stage
   import if_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [ADDR_W-1:0]      prog_count,
   output logic                   pc_take,
   input  logic                   flush,
   output logic                   imem_req,
   output logic [ADDR_W-1:0]      imem_addr,
   input  logic                   imem_ack,
   input  logic [DATA_W-1:0]      imem_rdata,
   output logic                   id_valid,
   input  logic                   id_ready,
   output logic [DATA_W-1:0]      id_instr,
   output logic [ADDR_W-1:0]      id_pc,
   output logic                   fetch_err,
   output fetch_state_t           dbg_state,
   output logic [$clog2(DEPTH):0] dbg_count
);

   // Handshakes: a memory read completes on a cycle with imem_req && imem_ack;
   // decode takes the head on a cycle with id_valid && id_ready (unless flush is high).

   fetch_state_t      state_q, state_d;
   logic              imem_req_q, imem_req_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic              pc_take_q, pc_take_d;
   logic              fetch_err_q, fetch_err_d;

   logic              q_push;
   logic              q_pop;
   logic              q_empty;
   logic              q_full;

   fetch_queue #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_queue (
      .clock      (clock),
      .reset      (reset),
      .push       (q_push),
      .pop        (q_pop),
      .clear      (flush),
      .push_pc    (imem_addr_q),
      .push_instr (imem_rdata),
      .head_pc    (id_pc),
      .head_instr (id_instr),
      .empty      (q_empty),
      .full       (q_full),
      .count      (dbg_count)
   );

   assign id_valid  = !q_empty;
   assign q_pop     = id_valid && id_ready;
   assign pc_take   = pc_take_q;
   assign imem_req  = imem_req_q;
   assign imem_addr = imem_addr_q;
   assign fetch_err = fetch_err_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d     = state_q;
      imem_req_d  = imem_req_q;
      imem_addr_d = imem_addr_q;
      pc_take_d   = 1'b0;
      fetch_err_d = fetch_err_q && !flush;
      q_push      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!flush && !q_full) begin
               imem_req_d  = 1'b1;
               imem_addr_d = prog_count;
               pc_take_d   = 1'b1;
               state_d     = WAIT;
               if (prog_count[1:0] != 2'b00) begin
                  fetch_err_d = 1'b1;
               end
            end
         end
         WAIT: begin
            if (imem_ack) begin
               imem_req_d = 1'b0;
               q_push     = !flush;
               state_d    = IDLE;
            end else if (flush) begin
               state_d = DROP;
            end
         end
         DROP: begin
            // Memory cannot cancel a read; wait it out and discard the word.
            if (imem_ack) begin
               imem_req_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            imem_req_d = 1'b0;
            state_d    = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         imem_req_q  <= 1'b0;
         imem_addr_q <= '0;
         pc_take_q   <= 1'b0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         imem_req_q  <= imem_req_d;
         imem_addr_q <= imem_addr_d;
         pc_take_q   <= pc_take_d;
         fetch_err_q <= fetch_err_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a transaction-level model predicts issues, deliveries and
// fetch_err; a negedge monitor compares the DUT against it through an expected queue.
module tb_fetch_stage;
   import if_pkg::*;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2;
   localparam int W      = ADDR_W + DATA_W;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [ADDR_W-1:0] prog_count = '0;
   logic              pc_take;
   logic              flush = 1'b0;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack = 1'b0;
   logic [DATA_W-1:0] imem_rdata = '0;
   logic              id_valid;
   logic              id_ready = 1'b0;
   logic [DATA_W-1:0] id_instr;
   logic [ADDR_W-1:0] id_pc;
   logic              fetch_err;
   fetch_state_t      dbg_state;
   logic [1:0]        dbg_count;

   fetch_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .prog_count (prog_count),
      .pc_take    (pc_take),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .id_valid   (id_valid),
      .id_ready   (id_ready),
      .id_instr   (id_instr),
      .id_pc      (id_pc),
      .fetch_err  (fetch_err),
      .dbg_state  (dbg_state),
      .dbg_count  (dbg_count)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   // ---------------- stimulus knobs ----------------
   bit          run         = 1'b0;
   int unsigned flush_pct   = 0;
   int unsigned ready_pct   = 100;
   int unsigned ack_pct     = 100;
   bit          misalign_en = 1'b0;
   logic [ADDR_W-1:0] flush_target = '0;

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_errors = 0;
   int n_deliv  = 0;
   logic [W-1:0] exp_q[$];
   bit                exp_take    = 1'b0;
   bit                out         = 1'b0;
   bit                killed      = 1'b0;
   bit                exp_err     = 1'b0;
   bit                rst_pending = 1'b0;
   logic [ADDR_W-1:0] exp_addr    = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   // Program counter model plus decode/branch stimulus, driven just after each rising edge.
   always @(posedge clock) begin
      bit take_s, flush_s, rst_s;
      logic [ADDR_W-1:0] tgt_s;
      take_s  = pc_take;
      flush_s = flush;
      rst_s   = reset;
      tgt_s   = flush_target;
      #1;
      if (!rst_s)       prog_count = '0;
      else if (flush_s) prog_count = tgt_s;
      else if (take_s)  prog_count = prog_count + ADDR_W'(4);
      if (run) begin
         flush    = ($urandom_range(0, 99) < flush_pct);
         id_ready = ($urandom_range(0, 99) < ready_pct);
         flush_target = ADDR_W'($urandom);
         if (!misalign_en) flush_target[1:0] = 2'b00;
      end else begin
         flush = 1'b0;
      end
   end

   // Instruction memory: acks an outstanding read with a configurable probability.
   always @(posedge clock) begin
      #2;
      imem_ack   = reset && imem_req && ($urandom_range(0, 99) < ack_pct);
      imem_rdata = $urandom;
   end

   // Monitor + reference model, evaluated between edges when everything is stable.
   always @(negedge clock) begin
      int  size_now;
      bit  take_next;
      size_now = exp_q.size();
      if (rst_pending) begin
         check("rst_pc_take",   pc_take,   0);
         check("rst_imem_req",  imem_req,  0);
         check("rst_imem_addr", imem_addr, 0);
         check("rst_id_valid",  id_valid,  0);
         check("rst_id_instr",  id_instr,  0);
         check("rst_id_pc",     id_pc,     0);
         check("rst_fetch_err", fetch_err, 0);
         check("rst_state",     dbg_state, IDLE);
      end else begin
         check("pc_take", pc_take, exp_take);
         if (pc_take) begin
            exp_addr = prog_count;
            if (prog_count[1:0] != 2'b00) exp_err = 1'b1;
         end
         check("imem_req", imem_req, out);
         if (out) check("imem_addr", imem_addr, exp_addr);
         check("fetch_err", fetch_err, exp_err);
         check("id_valid", id_valid, size_now != 0);
         if (reset && id_valid && id_ready && !flush && size_now != 0) begin
            check("id_pc",    id_pc,    exp_q[0][W-1:DATA_W]);
            check("id_instr", id_instr, exp_q[0][DATA_W-1:0]);
            void'(exp_q.pop_front());
            n_deliv++;
         end
      end
      if (!reset) begin
         exp_q.delete();
         out         = 1'b0;
         killed      = 1'b0;
         exp_take    = 1'b0;
         exp_err     = 1'b0;
         rst_pending = 1'b1;
      end else begin
         rst_pending = 1'b0;
         take_next = !out && !flush && (size_now < DEPTH);
         if (out && imem_ack) begin
            if (!killed && !flush) exp_q.push_back({exp_addr, imem_rdata});
            out = 1'b0;
         end else if (out && flush) begin
            killed = 1'b1;
         end
         if (flush) begin
            exp_q.delete();
            exp_err = 1'b0;
         end
         if (take_next) begin
            out    = 1'b1;
            killed = 1'b0;
         end
         exp_take = take_next;
         if (exp_q.size() > DEPTH) begin
            n_checks++;
            n_errors++;
            $display("FAIL model_depth: got %0d entries expected at most %0d", exp_q.size(), DEPTH);
         end
      end
   end

   task automatic phase(input int cycles, input int unsigned f_pct, input int unsigned r_pct,
                        input int unsigned a_pct, input bit mis);
      flush_pct   = f_pct;
      ready_pct   = r_pct;
      ack_pct     = a_pct;
      misalign_en = mis;
      repeat (cycles) @(posedge clock);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit got_req;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      run = 1'b1;
      phase(40,  0, 100, 100, 1'b0);   // single-cycle acks, decode always ready
      phase(20,  0,   0, 100, 1'b0);   // decode stalled: queue fills to DEPTH
      phase(40,  0, 100, 100, 1'b0);   // drain in order, fetch resumes
      phase(150, 0,  70,  25, 1'b0);   // long ack latency
      phase(300, 10, 60,  50, 1'b0);   // branch flushes, including in-flight reads
      phase(200, 5,  60,  60, 1'b1);   // misaligned branch targets raise fetch_err

      // Reset in the middle of an outstanding read.
      phase(0, 0, 100, 0, 1'b0);
      got_req = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (imem_req) begin
            got_req = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!got_req) begin
         n_errors++;
         $display("FAIL wait_req: got no imem_req within 50 cycles expected one");
      end
      @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
      phase(40, 0, 100, 100, 1'b0);

      run = 1'b0;
      repeat (3) @(posedge clock);
      n_checks++;
      if (n_deliv < 50) begin
         n_errors++;
         $display("FAIL deliveries: got %0d expected at least 50", n_deliv);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
